// File: rtl/axis_rgb_pixel_expander.sv
// axis_rgb_pixel_expander: AXI4-Stream RGB pixel widener behind a registered two-slot skid stage.
// Define RGB_EXP_COUNTERS_EN to add the o_pixel_count / o_line_count outputs.

module axis_rgb_pixel_expander_chan #(
  parameter int W     = 5,
  parameter int OUT_W = 8
) (
  input  logic [W-1:0]     x,
  input  logic             rep,
  output logic [OUT_W-1:0] y
);
  if (W == OUT_W) begin : g_pass
    logic unused_rep;
    assign unused_rep = rep;
    assign y          = x;
  end else begin : g_fill
    // The low bits are refilled from the channel's own MSBs; 2*W >= OUT_W keeps the slice in range.
    assign y = {x, rep ? x[W-1 -: OUT_W-W] : {(OUT_W-W){1'b0}}};
  end
endmodule

module axis_rgb_pixel_expander #(
  parameter int R_W   = 5,
  parameter int G_W   = 6,
  parameter int B_W   = 5,
  parameter int OUT_W = 8,
  localparam int IN_W = R_W + G_W + B_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mode,
  input  logic [IN_W-1:0]    s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tuser,
  input  logic               s_axis_tlast,
  output logic [3*OUT_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast
`ifdef RGB_EXP_COUNTERS_EN
  ,
  output logic [15:0]        o_pixel_count,
  output logic [15:0]        o_line_count
`endif
);

  if (R_W < 1 || R_W > OUT_W || 2*R_W < OUT_W ||
      G_W < 1 || G_W > OUT_W || 2*G_W < OUT_W ||
      B_W < 1 || B_W > OUT_W || 2*B_W < OUT_W) begin : g_bad_width
    $error("axis_rgb_pixel_expander: each channel width must lie in [ceil(OUT_W/2), OUT_W]");
  end

  typedef struct packed {
    logic [3*OUT_W-1:0] data;
    logic               user;
    logic               last;
  } beat_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

  logic [OUT_W-1:0] r_exp, g_exp, b_exp;
  beat_t            in_beat;
  state_e           state_q, state_d;
  beat_t            or_q, or_d, sk_q, sk_d;
  logic             ready_q, ready_d;
  logic             accept, xfer;

  axis_rgb_pixel_expander_chan #(.W(R_W), .OUT_W(OUT_W)) u_red (
    .x(s_axis_tdata[IN_W-1 -: R_W]), .rep(i_mode), .y(r_exp));
  axis_rgb_pixel_expander_chan #(.W(G_W), .OUT_W(OUT_W)) u_green (
    .x(s_axis_tdata[G_W+B_W-1 -: G_W]), .rep(i_mode), .y(g_exp));
  axis_rgb_pixel_expander_chan #(.W(B_W), .OUT_W(OUT_W)) u_blue (
    .x(s_axis_tdata[B_W-1:0]), .rep(i_mode), .y(b_exp));

  assign in_beat = '{data: {r_exp, g_exp, b_exp}, user: s_axis_tuser, last: s_axis_tlast};
  assign accept  = s_axis_tvalid && ready_q;
  assign xfer    = m_axis_tvalid && m_axis_tready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          or_d    = in_beat;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          or_d = in_beat;
        end else if (accept) begin
          sk_d    = in_beat;
          state_d = ST_FULL;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          or_d    = sk_q;
          sk_d    = '0;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (i_rst) begin
      // NOTE: the data slots are reset too, because tdata/tuser/tlast must read zero during reset.
      state_q <= ST_EMPTY;
      or_q    <= '0;
      sk_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sk_q    <= sk_d;
      ready_q <= ready_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = (state_q != ST_EMPTY);
  assign m_axis_tdata  = or_q.data;
  assign m_axis_tuser  = or_q.user;
  assign m_axis_tlast  = or_q.last;

`ifdef RGB_EXP_COUNTERS_EN
  logic [15:0] pixel_q, pixel_d, line_q, line_d;
  logic        eol_q, eol_d;

  always_comb begin
    // The pixel count parks at the line length for one cycle after tlast, then drops to zero.
    pixel_d = eol_q ? 16'd0 : pixel_q;
    line_d  = line_q;
    eol_d   = xfer && m_axis_tlast;
    if (xfer) begin
      pixel_d = m_axis_tuser ? 16'd1 : pixel_d + 16'd1;
      line_d  = (m_axis_tuser ? 16'd0 : line_q) + {15'd0, m_axis_tlast};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pixel_q <= '0;
      line_q  <= '0;
      eol_q   <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
      line_q  <= line_d;
      eol_q   <= eol_d;
    end
  end

  assign o_pixel_count = pixel_q;
  assign o_line_count  = line_q;
`endif

endmodule
